// File: rtl/l2_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : l2_mem_arbiter_rr
// Function : N-channel round-robin line-request arbiter in front of one L2 port.
//            Define ARB_FIXED_PRIORITY_EN to use fixed priority (lowest index wins).
// Revision : 1.0
// ============================================================================
module l2_mem_arbiter_rr #(
  parameter int NUM_CH     = 2,
  parameter int LINE_WIDTH = 128,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_read,
  input  logic [NUM_CH-1:0]            req_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_address,
  input  logic [NUM_CH*LINE_WIDTH-1:0] req_wdata,
  output logic [NUM_CH-1:0]            req_resp,
  output logic [LINE_WIDTH-1:0]        req_rdata,
  output logic                         l2_mem_read,
  output logic                         l2_mem_write,
  output logic [ADDR_WIDTH-1:0]        l2_mem_address,
  output logic [LINE_WIDTH-1:0]        l2_mem_wdata,
  input  logic                         l2_mem_resp,
  input  logic [LINE_WIDTH-1:0]        l2_mem_rdata_in
);

  localparam int c_GRANT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_GRANT_W-1:0]    r_grant;
  logic [c_GRANT_W-1:0]    r_last_grant;
  logic                    r_op_write;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [LINE_WIDTH-1:0]   r_wdata;
  logic [LINE_WIDTH-1:0]   r_rdata;

  logic [NUM_CH-1:0]       w_active;
  logic                    w_any;
  logic [c_GRANT_W-1:0]    w_sel;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [LINE_WIDTH-1:0]   w_sel_wdata;
  logic                    w_sel_write;

  assign w_active = req_read | req_write;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_any = |w_active;
    w_sel = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (w_active[c]) w_sel = c_GRANT_W'(c);
    end
  end
`else
  logic [NUM_CH-1:0] w_upper;

  // Channels above last_grant take precedence; otherwise wrap to the lowest active.
  always_comb begin
    w_any   = |w_active;
    w_sel   = '0;
    w_upper = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_upper[c] = w_active[c] && (c_GRANT_W'(c) > r_last_grant);
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (w_upper != '0) begin
        if (w_upper[c]) w_sel = c_GRANT_W'(c);
      end else if (w_active[c]) begin
        w_sel = c_GRANT_W'(c);
      end
    end
  end
`endif

  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_write = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_sel == c_GRANT_W'(c)) begin
        w_sel_addr  = req_address[c*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[c*LINE_WIDTH +: LINE_WIDTH];
        w_sel_write = req_write[c];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  always_comb begin
    w_state_nxt  = r_state;
    l2_mem_read  = 1'b0;
    l2_mem_write = 1'b0;
    req_resp     = '0;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        l2_mem_read  = ~r_op_write;
        l2_mem_write = r_op_write;
        if (l2_mem_resp) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        for (int c = 0; c < NUM_CH; c++) begin
          req_resp[c] = (r_grant == c_GRANT_W'(c));
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant      <= '0;
      r_last_grant <= c_GRANT_W'(NUM_CH - 1);
      r_op_write   <= 1'b0;
      r_address    <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
        r_op_write   <= w_sel_write;
        r_address    <= w_sel_addr;
        r_wdata      <= w_sel_wdata;
      end
      if (r_state == S_BUSY && l2_mem_resp && !r_op_write) begin
        r_rdata <= l2_mem_rdata_in;
      end
    end
  end

  assign l2_mem_address = r_address;
  assign l2_mem_wdata   = r_wdata;
  assign req_rdata      = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_l2_mem_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_mem_arbiter_rr
// Function : Directed vector bench for l2_mem_arbiter_rr with four channels.
// Revision : 1.0
// ============================================================================
module tb_l2_mem_arbiter_rr;

  localparam int NUM_CH = 4;
  localparam int LW     = 128;
  localparam int AW     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] req_read;
  logic [NUM_CH-1:0] req_write;
  logic [NUM_CH*AW-1:0] req_address;
  logic [NUM_CH*LW-1:0] req_wdata;
  logic [NUM_CH-1:0] req_resp;
  logic [LW-1:0]     req_rdata;
  logic              l2_mem_read;
  logic              l2_mem_write;
  logic [AW-1:0]     l2_mem_address;
  logic [LW-1:0]     l2_mem_wdata;
  logic              l2_mem_resp;
  logic [LW-1:0]     l2_mem_rdata_in;

  logic [AW-1:0]     addr_ch [NUM_CH];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  assign req_address = {addr_ch[3], addr_ch[2], addr_ch[1], addr_ch[0]};
  assign req_wdata   = {{16{8'h33}}, {16{8'h22}}, {16{8'h11}}, {16{8'hA5}}};

  l2_mem_arbiter_rr #(.NUM_CH(NUM_CH), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_address    (req_address),
    .req_wdata      (req_wdata),
    .req_resp       (req_resp),
    .req_rdata      (req_rdata),
    .l2_mem_read    (l2_mem_read),
    .l2_mem_write   (l2_mem_write),
    .l2_mem_address (l2_mem_address),
    .l2_mem_wdata   (l2_mem_wdata),
    .l2_mem_resp    (l2_mem_resp),
    .l2_mem_rdata_in(l2_mem_rdata_in)
  );

  typedef struct {
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic        rsp;
    logic [31:0] rdat;
    logic        e_rd;
    logic        e_wr;
    logic [15:0] e_addr;
    logic [3:0]  e_resp;
    logic [31:0] e_rdata;
    logic [7:0]  e_wd;
  } vec_t;

  vec_t vec [32];
  int   n_vec;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for an L2 strobe, return the accepted address and respond.
  task automatic serve(input string nm, input int exp_ch, input logic [31:0] data);
    int w;
    w = 0;
    while (!(l2_mem_read || l2_mem_write) && w < 8) begin
      step();
      w++;
    end
    chk({nm, " strobe"}, 128'(l2_mem_read || l2_mem_write), 128'(1));
    chk({nm, " addr"}, 128'(l2_mem_address), 128'(addr_ch[exp_ch]));
    l2_mem_rdata_in = {4{data}};
    l2_mem_resp = 1'b1;
    step();
    l2_mem_resp = 1'b0;
    chk({nm, " resp"}, 128'(req_resp), 128'(4'b0001 << exp_ch));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int exp_order [3];

    rst = 1'b1;
    req_read = '0;
    req_write = '0;
    l2_mem_resp = 1'b0;
    l2_mem_rdata_in = '0;
    addr_ch[0] = 16'h4000;
    addr_ch[1] = 16'h1230;
    addr_ch[2] = 16'h2222;
    addr_ch[3] = 16'h3333;

    vec[0]  = '{4'b0010, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0, 16'h1230, 4'b0000, 32'h0,        8'h11};
    vec[1]  = '{4'b0010, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0, 16'h1230, 4'b0000, 32'h0,        8'h11};
    vec[2]  = '{4'b0010, 4'b0000, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 16'h1230, 4'b0010, 32'hDEADBEEF, 8'h11};
    vec[3]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 16'h1230, 4'b0000, 32'hDEADBEEF, 8'h11};
    vec[4]  = '{4'b0000, 4'b0001, 1'b0, 32'h0,        1'b0, 1'b1, 16'h4000, 4'b0000, 32'hDEADBEEF, 8'hA5};
    vec[5]  = '{4'b0000, 4'b0001, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 16'h4000, 4'b0001, 32'hDEADBEEF, 8'hA5};
    vec[6]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 16'h4000, 4'b0000, 32'hDEADBEEF, 8'hA5};
    vec[7]  = '{4'b0100, 4'b0100, 1'b0, 32'h0,        1'b0, 1'b1, 16'h2222, 4'b0000, 32'hDEADBEEF, 8'h22};
    vec[8]  = '{4'b0100, 4'b0100, 1'b1, 32'h13572468, 1'b0, 1'b0, 16'h2222, 4'b0100, 32'hDEADBEEF, 8'h22};
    vec[9]  = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 16'h2222, 4'b0000, 32'hDEADBEEF, 8'h22};
    vec[10] = '{4'b0000, 4'b0000, 1'b1, 32'h12345678, 1'b0, 1'b0, 16'h2222, 4'b0000, 32'hDEADBEEF, 8'h22};
    n_vec = 11;
`ifndef ARB_FIXED_PRIORITY_EN
    vec[11] = '{4'b1111, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0, 16'h3333, 4'b0000, 32'hDEADBEEF, 8'h33};
    vec[12] = '{4'b1111, 4'b0000, 1'b1, 32'h00000003, 1'b0, 1'b0, 16'h3333, 4'b1000, 32'h00000003, 8'h33};
    vec[13] = '{4'b0111, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 16'h3333, 4'b0000, 32'h00000003, 8'h33};
    vec[14] = '{4'b0111, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0, 16'h4000, 4'b0000, 32'h00000003, 8'hA5};
    vec[15] = '{4'b0111, 4'b0000, 1'b1, 32'h0000000A, 1'b0, 1'b0, 16'h4000, 4'b0001, 32'h0000000A, 8'hA5};
    vec[16] = '{4'b0111, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 16'h4000, 4'b0000, 32'h0000000A, 8'hA5};
    vec[17] = '{4'b0111, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0, 16'h1230, 4'b0000, 32'h0000000A, 8'h11};
    vec[18] = '{4'b0111, 4'b0000, 1'b1, 32'hAAAAAAAA, 1'b0, 1'b0, 16'h1230, 4'b0010, 32'hAAAAAAAA, 8'h11};
    vec[19] = '{4'b0101, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 16'h1230, 4'b0000, 32'hAAAAAAAA, 8'h11};
    vec[20] = '{4'b0101, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0, 16'h2222, 4'b0000, 32'hAAAAAAAA, 8'h22};
    vec[21] = '{4'b0101, 4'b0000, 1'b1, 32'hBBBBBBBB, 1'b0, 1'b0, 16'h2222, 4'b0100, 32'hBBBBBBBB, 8'h22};
    vec[22] = '{4'b0001, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 16'h2222, 4'b0000, 32'hBBBBBBBB, 8'h22};
    vec[23] = '{4'b0001, 4'b0000, 1'b0, 32'h0,        1'b1, 1'b0, 16'h4000, 4'b0000, 32'hBBBBBBBB, 8'hA5};
    vec[24] = '{4'b0001, 4'b0000, 1'b1, 32'hC0C0C0C0, 1'b0, 1'b0, 16'h4000, 4'b0001, 32'hC0C0C0C0, 8'hA5};
    vec[25] = '{4'b0000, 4'b0000, 1'b0, 32'h0,        1'b0, 1'b0, 16'h4000, 4'b0000, 32'hC0C0C0C0, 8'hA5};
    n_vec = 26;
`endif

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset read",  128'(l2_mem_read),    128'(0));
    chk("reset write", 128'(l2_mem_write),   128'(0));
    chk("reset addr",  128'(l2_mem_address), 128'(0));
    chk("reset resp",  128'(req_resp),       128'(0));
    chk("reset rdata", req_rdata,            128'(0));
    chk("reset wdata", l2_mem_wdata,         128'(0));

    for (int i = 0; i < n_vec; i++) begin
      req_read        = vec[i].rd;
      req_write       = vec[i].wr;
      l2_mem_resp     = vec[i].rsp;
      l2_mem_rdata_in = {4{vec[i].rdat}};
      step();
      chk($sformatf("v%0d read", i),  128'(l2_mem_read),    128'(vec[i].e_rd));
      chk($sformatf("v%0d write", i), 128'(l2_mem_write),   128'(vec[i].e_wr));
      chk($sformatf("v%0d addr", i),  128'(l2_mem_address), 128'(vec[i].e_addr));
      chk($sformatf("v%0d resp", i),  128'(req_resp),       128'(vec[i].e_resp));
      chk($sformatf("v%0d rdata", i), req_rdata,            {4{vec[i].e_rdata}});
      chk($sformatf("v%0d wdata", i), l2_mem_wdata,         {16{vec[i].e_wd}});
    end
    req_read = '0;
    req_write = '0;
    l2_mem_resp = 1'b0;
    step();

    // Address change while BUSY must not reach the L2 port.
    addr_ch[0] = 16'h0100;
    req_read = 4'b0001;
    step();
    chk("stab addr0", 128'(l2_mem_address), 128'(16'h0100));
    addr_ch[0] = 16'h0200;
    step();
    chk("stab addr1", 128'(l2_mem_address), 128'(16'h0100));
    chk("stab read",  128'(l2_mem_read),    128'(1));
    l2_mem_resp = 1'b1;
    l2_mem_rdata_in = {4{32'h55667788}};
    step();
    l2_mem_resp = 1'b0;
    chk("stab addr2", 128'(l2_mem_address), 128'(16'h0100));
    chk("stab resp",  128'(req_resp),       128'(4'b0001));
    req_read = '0;
    addr_ch[0] = 16'h4000;
    step();

    // Asynchronous reset in the middle of a BUSY read.
    req_read = 4'b0010;
    step();
    chk("arst busy read", 128'(l2_mem_read), 128'(1));
    #3;
    rst = 1'b1;
    #1;
    chk("arst read drop", 128'(l2_mem_read), 128'(0));
    chk("arst resp",      128'(req_resp),    128'(0));
    step();
    chk("arst resp edge", 128'(req_resp),       128'(0));
    chk("arst addr",      128'(l2_mem_address), 128'(0));
    rst = 1'b0;
    req_read = 4'b0011;
    step();
    chk("arst first addr", 128'(l2_mem_address), 128'(16'h4000));
    chk("arst first read", 128'(l2_mem_read),    128'(1));
    l2_mem_resp = 1'b1;
    step();
    l2_mem_resp = 1'b0;
    chk("arst first resp", 128'(req_resp), 128'(4'b0001));
    req_read = '0;
    step();

    // All four channels contend from reset; each drops after its response.
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_read = 4'b1111;
    for (int k = 0; k < NUM_CH; k++) begin
      serve($sformatf("cont%0d", k), k, 32'h100 + k);
      req_read[k] = 1'b0;
      step();
    end

    // Channels 0 and 1 keep requesting across several transactions.
`ifdef ARB_FIXED_PRIORITY_EN
    exp_order = '{0, 0, 0};
`else
    exp_order = '{0, 1, 0};
`endif
    req_read = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      serve($sformatf("prio%0d", k), exp_order[k], 32'h200 + k);
      step();
    end
    req_read = '0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_mem_arbiter_rr.md
Name: l2_mem_arbiter_rr

Overview:
- Parametrised N-channel line-request arbiter between the L1-side requesters (I-cache, victim/D-cache, future prefetcher) and the single L2 cache port.
- Replaces the fixed two-channel arbiter with round-robin grant selection and registered request buffering. The buffer holds the L2 address, write data and read/write strobes stable for the whole transaction.
- Returns L2 read data to the granted channel with a one-cycle response pulse.

Parameters:
- NUM_CH, 2, number of requesting channels (2..8); channel index 0..NUM_CH-1.
- LINE_WIDTH, 128, cache line width in bits.
- ADDR_WIDTH, 16, address width in bits.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- req_read  input  NUM_CH  per-channel line read request, held until req_resp.
- req_write  input  NUM_CH  per-channel line write request, held until req_resp.
- req_address  input  NUM_CH*ADDR_WIDTH  channel c occupies bits [c*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  input  NUM_CH*LINE_WIDTH  channel c occupies bits [c*LINE_WIDTH +: LINE_WIDTH].
- req_resp  output  NUM_CH  one-hot, one-cycle completion pulse to the granted channel.
- req_rdata  output  LINE_WIDTH  registered L2 read data, broadcast to all channels.
- l2_mem_read  output  1  read strobe to L2.
- l2_mem_write  output  1  write strobe to L2.
- l2_mem_address  output  ADDR_WIDTH  latched address of the granted request.
- l2_mem_wdata  output  LINE_WIDTH  latched write data of the granted request.
- l2_mem_resp  input  1  L2 completion.
- l2_mem_rdata_in  input  LINE_WIDTH  L2 read data, valid when l2_mem_resp=1.

Behaviour:
- Reset (async, immediate): state=IDLE, all outputs 0, grant register 0, last_grant=NUM_CH-1, so channel 0 wins first.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - A channel is active if req_read[c] or req_write[c] is set.
  - If any channel is active, select the first active channel scanning last_grant+1, +2, … modulo NUM_CH (wrap-around).
  - Latch grant, address, wdata and op; op=write if req_write[c] is set, else read. Write wins if both are set.
  - Set last_grant=grant and go to BUSY.
  - No active channel: stay in IDLE.
- BUSY:
  - l2_mem_read/l2_mem_write driven from the latched op (exactly one high); address and wdata come from the latched registers.
  - Requester inputs are ignored; changes to a requester's inputs mid-transaction have no effect.
  - On l2_mem_resp=1: latch l2_mem_rdata_in into req_rdata (reads only; writes leave req_rdata unchanged) and go to RESP. Strobes drop in RESP.
- RESP:
  - req_resp[grant]=1 for exactly one cycle, then IDLE.
  - Gives the requester one cycle to drop its request before re-arbitration.
- Latency: request visible in IDLE at cycle t; L2 strobe at t+1; L2 resp at cycle k gives req_resp at k+1. Minimum 3 cycles request-to-resp.
- Back-to-back: a channel still requesting in the IDLE after its RESP is eligible, but only after other active channels in rotation order.
- Fairness: with all channels continuously requesting, grants rotate 0,1,…,NUM_CH-1,0.
- Simultaneous l2_mem_resp in IDLE or RESP: ignored.
- req_rdata holds its value until the next read completion.
- Reset mid-BUSY: strobes deassert asynchronously, transaction abandoned, no req_resp issued.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: round-robin is replaced by fixed priority; the lowest active channel index always wins (channel 0 = I-cache highest). last_grant is still updated but unused.
- Undefined: round-robin as above.
- Latency and handshake are identical either way.

Test Plan:
- Single read, NUM_CH=2: ch1 read addr 0x1230; L2 resp 2 cycles after strobe with data 0xDEADBEEF…; expected response:
  - l2_mem_address=0x1230, l2_mem_read=1 for 2 cycles.
  - req_resp=2'b10 one cycle later, req_rdata=0xDEADBEEF….
- Single write: ch0 write addr 0x4000, wdata 0xA5 repeated; expected response:
  - l2_mem_write=1, l2_mem_wdata=0xA5 repeated, l2_mem_read=0.
  - req_resp=2'b01, req_rdata unchanged.
- Contention, NUM_CH=4: all four channels hold read requests; each is dropped after its resp. Expected grant order 0,1,2,3; no channel granted twice before all served.
- Wrap-around, NUM_CH=3: last_grant=2, ch0 and ch2 request → ch0 granted, then ch2.
- Input stability: ch0 read addr 0x0100 granted, then ch0 changes address to 0x0200 mid-BUSY → l2_mem_address stays 0x0100 until resp.
- Async reset during BUSY: assert rst between clock edges. Expected: l2_mem_read falls before the next edge, req_resp stays 0, the first grant after reset release goes to ch0. With ARB_FIXED_PRIORITY_EN: ch0 and ch1 requesting repeatedly → ch0 always wins.
